// File: rtl/sodor_rand_instr_gen.sv
// Seedable LFSR-driven RV32I ALU instruction source (I/R/mixed/NOP) with valid/ready output.
// Define STIM_HAZARD_BIAS_EN to bias rs1 toward the previous accepted rd (RAW hazards).
module sodor_rand_instr_gen #(
  parameter int          NUM_REGS = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_instrs,
  output logic [31:0]      out_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] issued,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0]  RMASK = 5'(NUM_REGS - 1);
  localparam logic [31:0] TAPS  = 32'h8020_0003;
`ifdef STIM_HAZARD_BIAS_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  state_t           state;
  logic [31:0]      lfsr;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] budget;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] form_word(input logic [31:0] r, input logic [1:0] m,
                                            input logic [4:0] lrd);
    logic [11:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        use_r;
    imm = r[31:20];
    rs1 = r[19:15] & RMASK;
    f3  = r[14:12];
    rd  = r[11:7] & RMASK;
    rs2 = r[24:20] & RMASK;
    if (HZ_EN && r[5:4] == 2'b00 && lrd != 5'd0) rs1 = lrd;
    // shift-immediates only carry shamt (plus the arithmetic bit for srai)
    if (f3 == 3'd1)      imm = imm & 12'h01F;
    else if (f3 == 3'd5) imm = imm & 12'h41F;
    f7 = (r[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
    case (m)
      2'd0:    use_r = 1'b0;
      2'd1:    use_r = 1'b1;
      default: use_r = r[0];
    endcase
    if (m == 2'd3) return NOP_WORD;
    if (use_r)     return {f7, rs2, rs1, f3, rd, 7'h33};
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  logic [31:0] seed_eff, lfsr_nxt;
  logic [4:0]  acc_rd;
  logic        accept;

  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;
  assign lfsr_nxt = lfsr_step(lfsr);
  // the word being accepted this cycle carries the rd the next word may depend on
  assign acc_rd   = HZ_EN ? out_instr[11:7] : 5'd0;
  assign accept   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= 32'h1;
      mode_q    <= 2'd0;
      budget    <= '0;
      out_instr <= NOP_WORD;
      out_valid <= 1'b0;
      issued    <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          lfsr   <= seed_eff;
          mode_q <= mode;
          budget <= num_instrs;
          issued <= '0;
          if (num_instrs == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            out_valid <= 1'b0;
            out_instr <= NOP_WORD;
          end else begin
            state     <= RUN;
            done      <= 1'b0;
            out_valid <= 1'b1;
            out_instr <= form_word(seed_eff, mode, 5'd0);
          end
        end
        RUN: if (accept) begin
          lfsr   <= lfsr_nxt;
          issued <= issued + CNT_W'(1);
          if (issued + CNT_W'(1) == budget) begin
            state     <= DONE;
            done      <= 1'b1;
            out_valid <= 1'b0;
            out_instr <= NOP_WORD;
          end else begin
            out_instr <= form_word(lfsr_nxt, mode_q, acc_rd);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sodor_rand_instr_gen.sv
// Directed bench for sodor_rand_instr_gen: hand-decoded words, handshake, budget and reset.
module tb_sodor_rand_instr_gen;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [31:0] seed = '0;
  logic [1:0]  mode = '0;
  logic [15:0] num_instrs = '0;
  logic [31:0] out_instr, out_instr8;
  logic        out_valid, out_valid8, done, done8;
  logic [15:0] issued, issued8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sodor_rand_instr_gen #(.NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .mode(mode),
    .num_instrs(num_instrs), .out_instr(out_instr), .out_valid(out_valid),
    .out_ready(out_ready), .issued(issued), .done(done));

  sodor_rand_instr_gen #(.NUM_REGS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .mode(mode),
    .num_instrs(num_instrs), .out_instr(out_instr8), .out_valid(out_valid8),
    .out_ready(out_ready), .issued(issued8), .done(done8));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [1:0] m, input logic [15:0] n);
    seed = s; mode = m; num_instrs = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", out_instr, NOP); end
    n_checks++; if (issued !== 16'd0) begin n_fail++; $display("FAIL reset_issued got %0d want 0", issued); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_itype_single();
    out_ready = 1'b1;
    do_start(32'h1234_5678, 2'd0, 16'd1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL itype_valid got %b want 1", out_valid); end
    n_checks++; if (out_instr !== 32'h0034_5613) begin n_fail++; $display("FAIL itype_word got %h want 00345613", out_instr); end
    n_checks++; if (out_instr8 !== 32'h0030_5213) begin n_fail++; $display("FAIL itype_word_nr8 got %h want 00305213", out_instr8); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL itype_done got %b want 1", done); end
    n_checks++; if (issued !== 16'd1) begin n_fail++; $display("FAIL itype_issued got %0d want 1", issued); end
    n_checks++; if (out_instr !== NOP || out_valid !== 1'b0) begin n_fail++; $display("FAIL itype_idle got %h/%b want %h/0", out_instr, out_valid, NOP); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_start(32'h1234_5678, 2'd0, 16'd2);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_instr !== 32'h0034_5613 || out_valid !== 1'b1 || issued !== 16'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %h/%b/%0d want 00345613/1/0", i, out_instr, out_valid, issued); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (issued !== 16'd1) begin n_fail++; $display("FAIL bp_issued1 got %0d want 1", issued); end
    n_checks++; if (out_instr !== 32'h091A_2B13) begin n_fail++; $display("FAIL bp_second got %h want 091a2b13", out_instr); end
    tick();
    n_checks++; if (done !== 1'b1 || issued !== 16'd2) begin n_fail++; $display("FAIL bp_done got %b/%0d want 1/2", done, issued); end
  endtask

  task automatic test_zero_budget();
    out_ready = 1'b1;
    do_start(32'hDEAD_BEEF, 2'd0, 16'd0);
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_done got %b/%b want 1/0", done, out_valid); end
    n_checks++; if (issued !== 16'd0 || out_instr !== NOP) begin n_fail++; $display("FAIL zero_state got %0d/%h want 0/%h", issued, out_instr, NOP); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_later got %b want 0", out_valid); end
  endtask

  task automatic test_word_forms();
    logic [31:0] seeds [6] = '{32'h1234_5678, 32'h4000_0000, 32'hFFF0_1000, 32'h4000_0001, 32'h1234_5678, 32'h0};
    logic [1:0]  modes [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1};
    logic [31:0] exps  [6] = '{32'h0034_5633, 32'h4000_0033, 32'h01F0_1013, 32'h4000_0033, 32'h0034_5613, 32'h0000_0033};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_start(seeds[i], modes[i], 16'd1);
      n_checks++; if (out_instr !== exps[i]) begin n_fail++; $display("FAIL form[%0d] got %h want %h", i, out_instr, exps[i]); end
      tick();
    end
    // seed 0 must be replaced by 1, so the second word comes from 0x80200003
    do_start(32'h0, 2'd1, 16'd2);
    tick();
    n_checks++; if (out_instr !== 32'h0020_0033) begin n_fail++; $display("FAIL seed0_second got %h want 00200033", out_instr); end
    tick();
  endtask

  task automatic test_nop_only();
    out_ready = 1'b1;
    do_start(32'h1234_5678, 2'd3, 16'd3);
    n_checks++; if (out_instr !== NOP || out_valid !== 1'b1) begin n_fail++; $display("FAIL nop_word got %h/%b want %h/1", out_instr, out_valid, NOP); end
    tick(); tick(); tick();
    n_checks++; if (done !== 1'b1 || issued !== 16'd3) begin n_fail++; $display("FAIL nop_count got %b/%0d want 1/3", done, issued); end
  endtask

  task automatic test_start_in_run();
    out_ready = 1'b0;
    do_start(32'h1234_5678, 2'd0, 16'd3);
    do_start(32'h4000_0000, 2'd1, 16'd1);
    n_checks++; if (out_instr !== 32'h0034_5613 || issued !== 16'd0) begin n_fail++; $display("FAIL run_start_ignored got %h/%0d want 00345613/0", out_instr, issued); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_instr !== 32'h091A_2B13) begin n_fail++; $display("FAIL run_start_second got %h want 091a2b13", out_instr); end
    tick(); tick();
    n_checks++; if (done !== 1'b1 || issued !== 16'd3) begin n_fail++; $display("FAIL run_start_budget got %b/%0d want 1/3", done, issued); end
  endtask

  task automatic test_mixed_long();
    int          acc = 0;
    logic        stalled = 1'b0;
    logic [31:0] hold_w = '0, w;
    do_start(32'hCAFE_BABE, 2'd2, 16'd1000);
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (stalled) begin
        n_checks++; if (out_instr !== hold_w || out_valid !== 1'b1) begin n_fail++; $display("FAIL mix_stall got %h/%b want %h/1", out_instr, out_valid, hold_w); end
      end
      stalled = out_valid && !out_ready;
      hold_w  = out_instr;
      if (out_valid && out_ready) begin
        w = out_instr;
        acc++;
        n_checks++; if (w[6:0] !== 7'h13 && w[6:0] !== 7'h33) begin n_fail++; $display("FAIL mix_opcode got %h", w); end
        if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
          n_checks++; if (w[31] !== 1'b0 || w[29:25] !== 5'd0) begin n_fail++; $display("FAIL mix_shamt got %h want imm11=0 imm9_5=0", w); end
        end
        if (w[6:0] == 7'h33) begin
          n_checks++; if (!(w[31:25] == 7'h00 || (w[31:25] == 7'h20 && (w[14:12] == 3'd0 || w[14:12] == 3'd5)))) begin
            n_fail++; $display("FAIL mix_f7 got %h", w); end
        end
      end
      tick();
    end
    n_checks++; if (done !== 1'b1 || issued !== 16'd1000 || acc != 1000) begin
      n_fail++; $display("FAIL mix_total got done=%b issued=%0d acc=%0d want 1/1000/1000", done, issued, acc); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] cap [37];
    out_ready = 1'b1;
    do_start(32'h0BAD_F00D, 2'd2, 16'd100);
    n_checks++; if (out_instr !== 32'h01AD_F033) begin n_fail++; $display("FAIL mid_first got %h want 01adf033", out_instr); end
    for (int i = 0; i < 37; i++) begin cap[i] = out_instr; tick(); end
    n_checks++; if (issued !== 16'd37) begin n_fail++; $display("FAIL mid_issued got %0d want 37", issued); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || issued !== 16'd0 || out_instr !== NOP || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got %b/%0d/%h/%b want 0/0/%h/0", out_valid, issued, out_instr, done, NOP); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle got %b want 0", out_valid); end
    do_start(32'h0BAD_F00D, 2'd2, 16'd100);
    for (int i = 0; i < 37; i++) begin
      n_checks++; if (out_instr !== cap[i]) begin n_fail++; $display("FAIL mid_replay[%0d] got %h want %h", i, out_instr, cap[i]); end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_itype_single();
    test_backpressure();
    test_zero_budget();
    test_word_forms();
    test_nop_only();
    test_start_in_run();
    test_mixed_long();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
